// File: rtl/fixed_accumulator_if.sv
// Bundles the start/length command, the incoming fixed-point term stream and the
// result handshake of fixed_accumulator into one port group.
interface fixed_accumulator_if #(
    parameter int FX_B  = 64,
    parameter int CNT_W = 16,
    parameter int ACC_B = 72
) ();
    logic             start_i;
    logic [CNT_W-1:0] len_i;
    logic             fixed_valid_i;
    logic [FX_B-1:0]  fixed_i;
    logic             fixed_ready_o;
    logic             acc_valid_o;
    logic             acc_ready_i;
    logic [ACC_B-1:0] acc_o;
    logic             overflow_o;
    logic             busy_o;

    modport master (
        output start_i, len_i, fixed_valid_i, fixed_i, acc_ready_i,
        input  fixed_ready_o, acc_valid_o, acc_o, overflow_o, busy_o
    );

    modport slave (
        input  start_i, len_i, fixed_valid_i, fixed_i, acc_ready_i,
        output fixed_ready_o, acc_valid_o, acc_o, overflow_o, busy_o
    );
endinterface

// File: rtl/fixed_accumulator.sv
// Sums a programmed number of signed fixed-point terms into a wide guarded register.
// Optional macro FIXED_ACC_SATURATE_EN clamps the sum on overflow instead of wrapping.
module fixed_accumulator #(
    parameter int FX_M       = 16,
    parameter int FX_B       = 64,
    parameter int GUARD_BITS = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fixed_accumulator_if.slave bus
);
    localparam int ACC_B = FX_B + GUARD_BITS;
    localparam logic [ACC_B-1:0] AccMax = {1'b0, {(ACC_B-1){1'b1}}};
    localparam logic [ACC_B-1:0] AccMin = {1'b1, {(ACC_B-1){1'b0}}};

    if (FX_M > FX_B) begin : gBadFormat
        $error("fixed_accumulator: FX_M must not exceed FX_B");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_B-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;

    logic signed [FX_B-1:0]  termIn;
    logic signed [ACC_B-1:0] termExt;
    logic signed [ACC_B-1:0] sumRaw;
    logic signed [ACC_B-1:0] addResult;
    logic                    addOvf;
    logic                    startTaken;

    assign termIn  = bus.fixed_i;
    assign termExt = ACC_B'(termIn);
    assign sumRaw  = acc_q + termExt;
    // Overflow is only possible when both operands share a sign and the sum flips it.
    assign addOvf  = (acc_q[ACC_B-1] == termExt[ACC_B-1]) &&
                     (sumRaw[ACC_B-1] != acc_q[ACC_B-1]);

`ifdef FIXED_ACC_SATURATE_EN
    assign addResult = addOvf ? (acc_q[ACC_B-1] ? AccMin : AccMax) : sumRaw;
`else
    assign addResult = sumRaw;
`endif

    // A result being collected in DONE may hand straight over to the next start.
    assign startTaken = bus.start_i &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.acc_ready_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        case (state_q)
            ACCUM: begin
                if (bus.fixed_valid_i) begin
                    acc_d = addResult;
                    ovf_d = ovf_q | addOvf;
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end
                    if (count_q <= CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.acc_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (startTaken) begin
            acc_d = '0;
            ovf_d = 1'b0;
            if (bus.len_i != '0) begin
                count_d = bus.len_i;
                state_d = ACCUM;
            end else begin
                count_d = '0;
                state_d = DONE;
            end
        end
    end

    assign bus.fixed_ready_o = (state_q == ACCUM);
    assign bus.acc_valid_o   = (state_q == DONE);
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.acc_o         = acc_q;
    assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_fixed_accumulator.sv
// Scoreboard bench for fixed_accumulator: a 16-bit unguarded instance for most scenarios
// and an 8-guard-bit instance for the long-sum case.
module tb_fixed_accumulator;
    typedef struct {
        logic signed [63:0] acc;
        bit                 ovf;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   testsRun  = 0;
    int   failCount = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    fixed_accumulator_if #(.FX_B(16), .CNT_W(16), .ACC_B(16)) if0 ();
    fixed_accumulator_if #(.FX_B(16), .CNT_W(16), .ACC_B(24)) if1 ();

    fixed_accumulator #(.FX_M(8), .FX_B(16), .GUARD_BITS(0), .CNT_W(16)) dut0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (if0.slave)
    );

    fixed_accumulator #(.FX_M(8), .FX_B(16), .GUARD_BITS(8), .CNT_W(16)) dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (if1.slave)
    );

    // Reference sum computed on exact integers, then folded back into the accumulator range.
    function automatic void modelAcc(input logic [15:0] terms[$], input int accBits,
                                     output logic signed [63:0] accOut, output bit ovf);
        longint maxV, minV, acc, ex;
        maxV = (longint'(1) <<< (accBits - 1)) - 1;
        minV = -maxV - 1;
        acc  = 0;
        ovf  = 1'b0;
        foreach (terms[i]) begin
            ex = acc + longint'($signed(terms[i]));
            if (ex > maxV || ex < minV) begin
                ovf = 1'b1;
`ifdef FIXED_ACC_SATURATE_EN
                acc = (ex > maxV) ? maxV : minV;
`else
                acc = (ex > maxV) ? ex - 2 * (maxV + 1) : ex + 2 * (maxV + 1);
`endif
            end else begin
                acc = ex;
            end
        end
        accOut = acc;
    endfunction

    task automatic pushExpected(input logic [15:0] terms[$], input int accBits);
        exp_t e;
        modelAcc(terms, accBits, e.acc, e.ovf);
        sb.push_back(e);
    endtask

    task automatic startAcc(input logic [15:0] len);
        if0.start_i = 1'b1;
        if0.len_i   = len;
        @(negedge clk_i);
        if0.start_i = 1'b0;
    endtask

    task automatic sendTerms(input logic [15:0] terms[$], input int gapMax, output bit timedOut);
        int gap;
        int waitCyc;
        timedOut = 1'b0;
        foreach (terms[i]) begin
            gap = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
            repeat (gap) begin
                if0.fixed_valid_i = 1'b0;
                if0.start_i       = 1'($urandom_range(1, 0));
                if0.len_i         = 16'($urandom_range(7, 0));
                @(negedge clk_i);
            end
            if0.start_i       = 1'b0;
            if0.fixed_valid_i = 1'b1;
            if0.fixed_i       = terms[i];
            waitCyc = 0;
            while (!if0.fixed_ready_o && waitCyc < 20) begin
                @(negedge clk_i);
                waitCyc++;
            end
            if (!if0.fixed_ready_o) timedOut = 1'b1;
            @(negedge clk_i);
        end
        if0.fixed_valid_i = 1'b0;
    endtask

    task automatic waitValid(output bit timedOut);
        int n = 0;
        while (!if0.acc_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        timedOut = !if0.acc_valid_o;
    endtask

    task automatic ackResult();
        if0.acc_ready_i = 1'b1;
        @(negedge clk_i);
        if0.acc_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0]        terms[$];
        exp_t               e;
        bit                 to1, to2;
        logic signed [63:0] got;

        testsRun++;
        if ({if0.acc_valid_o, if0.fixed_ready_o, if0.overflow_o, if0.busy_o} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {if0.acc_valid_o, if0.fixed_ready_o, if0.overflow_o, if0.busy_o});
        end
        testsRun++;
        if (if0.acc_o !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_acc: got %h expected 0000", if0.acc_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);

        startAcc(16'd4);
        terms = '{16'h0011, 16'h0022};
        sendTerms(terms, 0, to1);
        rst_i = 1'b0;
        #1;
        testsRun++;
        if ({if0.acc_valid_o, if0.fixed_ready_o, if0.overflow_o, if0.busy_o, if0.acc_o} !== 20'h0) begin
            failCount++;
            $display("[TB] FAIL reset_mid_accum: flags %b acc %h expected all zero (send timeout %0b)",
                     {if0.acc_valid_o, if0.fixed_ready_o, if0.overflow_o, if0.busy_o}, if0.acc_o, to1);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        terms = '{16'h0005};
        pushExpected(terms, 16);
        startAcc(16'd1);
        sendTerms(terms, 0, to1);
        waitValid(to2);
        e   = sb.pop_front();
        got = 64'($signed(if0.acc_o));
        testsRun++;
        if (to1 || to2 || got !== e.acc || if0.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL after_reset_result: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                     got, if0.overflow_o, to1 | to2, e.acc, e.ovf);
        end
        ackResult();
    endtask

    task automatic test_back_to_back();
        logic [15:0]        terms[$];
        exp_t               e;
        bit                 to1, to2;
        logic signed [63:0] got;

        terms = '{16'h0100, 16'hFF00, 16'h0040};
        pushExpected(terms, 16);
        startAcc(16'd3);
        sendTerms(terms, 0, to1);
        testsRun++;
        if (if0.acc_valid_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL b2b_latency: acc_valid %b one cycle after last term, expected 1", if0.acc_valid_o);
        end
        waitValid(to2);
        e   = sb.pop_front();
        got = 64'($signed(if0.acc_o));
        testsRun++;
        if (to1 || to2 || got !== e.acc || if0.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL b2b_result: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                     got, if0.overflow_o, to1 | to2, e.acc, e.ovf);
        end
        ackResult();
    endtask

    task automatic test_zero_len();
        logic [15:0]        terms[$];
        exp_t               e;
        bit                 to;
        logic signed [63:0] got;

        terms = {};
        pushExpected(terms, 16);
        startAcc(16'd0);
        testsRun++;
        if (if0.acc_valid_o !== 1'b1 || if0.fixed_ready_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL zero_len_handshake: acc_valid %b fixed_ready %b expected 1 0",
                     if0.acc_valid_o, if0.fixed_ready_o);
        end
        waitValid(to);
        e   = sb.pop_front();
        got = 64'($signed(if0.acc_o));
        testsRun++;
        if (to || got !== e.acc || if0.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL zero_len_result: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                     got, if0.overflow_o, to, e.acc, e.ovf);
        end
        ackResult();
        testsRun++;
        if (if0.busy_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL zero_len_idle: busy %b expected 0", if0.busy_o);
        end
    endtask

    task automatic test_overflow_hold();
        logic [15:0]        terms[$];
        exp_t               e;
        bit                 to1, to2;
        logic signed [63:0] got;

        terms = '{16'h7000, 16'h2000};
        pushExpected(terms, 16);
        startAcc(16'd2);
        sendTerms(terms, 0, to1);
        waitValid(to2);
        e   = sb.pop_front();
        got = 64'($signed(if0.acc_o));
        testsRun++;
        if (to1 || to2 || got !== e.acc || if0.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL overflow_result: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                     got, if0.overflow_o, to1 | to2, e.acc, e.ovf);
        end

        if0.fixed_i = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            if0.fixed_valid_i = k[0];
            @(negedge clk_i);
            got = 64'($signed(if0.acc_o));
            testsRun++;
            if (if0.acc_valid_o !== 1'b1 || got !== e.acc || if0.overflow_o !== e.ovf) begin
                failCount++;
                $display("[TB] FAIL done_hold[%0d]: valid %b acc %0d ovf %b expected valid 1 acc %0d ovf %b",
                         k, if0.acc_valid_o, got, if0.overflow_o, e.acc, e.ovf);
            end
        end
        if0.fixed_valid_i = 1'b0;

        if0.acc_ready_i = 1'b1;
        if0.start_i     = 1'b1;
        if0.len_i       = 16'd1;
        @(negedge clk_i);
        if0.acc_ready_i = 1'b0;
        if0.start_i     = 1'b0;
        testsRun++;
        if ({if0.fixed_ready_o, if0.acc_valid_o, if0.overflow_o} !== 3'b100 || if0.acc_o !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL restart_from_done: ready/valid/ovf %b acc %h expected 100 acc 0000",
                     {if0.fixed_ready_o, if0.acc_valid_o, if0.overflow_o}, if0.acc_o);
        end

        terms = '{16'h0003};
        pushExpected(terms, 16);
        sendTerms(terms, 0, to1);
        waitValid(to2);
        e   = sb.pop_front();
        got = 64'($signed(if0.acc_o));
        testsRun++;
        if (to1 || to2 || got !== e.acc || if0.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL restart_result: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                     got, if0.overflow_o, to1 | to2, e.acc, e.ovf);
        end
        ackResult();
    endtask

    task automatic test_random();
        logic [15:0]        terms[$];
        exp_t               e;
        bit                 to1, to2;
        int                 len;
        logic signed [63:0] got;

        for (int r = 0; r < 5; r++) begin
            len   = $urandom_range(6, 1);
            terms = {};
            for (int j = 0; j < len; j++) terms.push_back(16'($urandom()));
            pushExpected(terms, 16);
            startAcc(16'(len));
            sendTerms(terms, 2, to1);
            waitValid(to2);
            repeat ($urandom_range(2, 0)) @(negedge clk_i);
            e   = sb.pop_front();
            got = 64'($signed(if0.acc_o));
            testsRun++;
            if (to1 || to2 || got !== e.acc || if0.overflow_o !== e.ovf) begin
                failCount++;
                $display("[TB] FAIL random[%0d] len %0d: acc %0d ovf %b (timeout %0b) expected acc %0d ovf %b",
                         r, len, got, if0.overflow_o, to1 | to2, e.acc, e.ovf);
            end
            ackResult();
        end
    endtask

    task automatic test_guard_bits();
        logic [15:0]        terms[$];
        exp_t               e;
        int                 accepted;
        int                 cyc;
        logic signed [63:0] got;

        terms = {};
        for (int j = 0; j < 256; j++) terms.push_back(16'h7FFF);
        pushExpected(terms, 24);

        if1.start_i = 1'b1;
        if1.len_i   = 16'd256;
        @(negedge clk_i);
        if1.start_i       = 1'b0;
        if1.fixed_valid_i = 1'b1;
        if1.fixed_i       = 16'h7FFF;
        accepted = 0;
        cyc      = 0;
        while (accepted < 256 && cyc < 400) begin
            if (if1.fixed_ready_o) accepted++;
            @(negedge clk_i);
            cyc++;
        end
        if1.fixed_valid_i = 1'b0;
        cyc = 0;
        while (!if1.acc_valid_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        e   = sb.pop_front();
        got = 64'($signed(if1.acc_o));
        testsRun++;
        if (!if1.acc_valid_o || got !== e.acc || if1.overflow_o !== e.ovf) begin
            failCount++;
            $display("[TB] FAIL guard_sum: valid %b acc %h ovf %b accepted %0d expected acc %h ovf %b",
                     if1.acc_valid_o, if1.acc_o, if1.overflow_o, accepted, e.acc[23:0], e.ovf);
        end
        if1.acc_ready_i = 1'b1;
        @(negedge clk_i);
        if1.acc_ready_i = 1'b0;
    endtask

    initial begin
        rst_i             = 1'b0;
        if0.start_i       = 1'b0;
        if0.len_i         = '0;
        if0.fixed_valid_i = 1'b0;
        if0.fixed_i       = '0;
        if0.acc_ready_i   = 1'b0;
        if1.start_i       = 1'b0;
        if1.len_i         = '0;
        if1.fixed_valid_i = 1'b0;
        if1.fixed_i       = '0;
        if1.acc_ready_i   = 1'b0;
        repeat (2) @(negedge clk_i);

        test_reset();
        test_back_to_back();
        test_zero_len();
        test_overflow_hold();
        test_random();
        test_guard_bits();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
